// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared SRAM geometry constants, pointer helpers and copy-engine FSM states
package sram_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 32;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} copy_state_e;

  function automatic ptr_t wrap_ptr(input logic [ADDR_W-1:0] a);
    return ptr_t'(32'(a) % 32'(DEPTH));
  endfunction

  function automatic ptr_t inc_ptr(input ptr_t p);
    return (32'(p) == 32'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic cnt_t clamp_len(input logic [ADDR_W-1:0] l);
    return (32'(l) > 32'(DEPTH)) ? cnt_t'(DEPTH) : cnt_t'(l);
  endfunction
endpackage

// File: rtl/sram_copy_addr_gen.sv
// rtl/sram_copy_addr_gen.sv - source/destination pointers with modulo-DEPTH wrap and remaining-word counter
module sram_copy_addr_gen
  import sram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic [PTR_W-1:0]  src_d_o,
  output logic [PTR_W-1:0]  dst_d_o,
  output logic              last_o
);
  ptr_t src_q, dst_q;
  cnt_t cnt_q, cnt_d;

  // Next-state pointers are exported so the top can register ADDRESS one cycle ahead.
  always_comb begin
    src_d_o = src_q;
    dst_d_o = dst_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      src_d_o = wrap_ptr(src_i);
      dst_d_o = wrap_ptr(dst_i);
      cnt_d   = clamp_len(len_i);
    end else if (step_i) begin
      src_d_o = inc_ptr(src_q);
      dst_d_o = inc_ptr(dst_q);
      cnt_d   = cnt_q - 1'b1;
    end
  end

  assign last_o = (cnt_q == cnt_t'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
    end else begin
      src_q <= src_d_o;
      dst_q <= dst_d_o;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sram_copy_engine.sv
// rtl/sram_copy_engine.sv - SRAM block-copy initiator (read/wait/write per word)
// Optional macro SRAM_COPY_CHECKSUM_EN adds an XOR checksum of every copied word.
module sram_copy_engine
  import sram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] WriteData,
  output logic              WriteEn,
  output logic              ReadEn,
  input  logic [DATA_W-1:0] ReadData
`ifdef SRAM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);
  copy_state_e       state_q, state_d;
  logic              load, step, last;
  logic [PTR_W-1:0]  src_d, dst_d;
  logic              busy_q, done_q, wr_q, rd_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  sram_copy_addr_gen u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .step_i (step),
    .src_i  (src_addr),
    .dst_i  (dst_addr),
    .len_i  (len),
    .src_d_o(src_d),
    .dst_d_o(dst_d),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (len == '0) ? DONE : READ;
        end
      end
      READ:  state_d = WAIT;
      WAIT:  state_d = WRITE;
      WRITE: begin
        step    = 1'b1;
        state_d = last ? DONE : READ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the bus is registered yet aligned with the state.
  // WriteData doubles as the capture register: it samples ReadData only at the end of WAIT.
  always_comb begin
    addr_d  = '0;
    wdata_d = '0;
    if (state_d == READ) begin
      addr_d = ADDR_W'(src_d);
    end else if (state_d == WRITE) begin
      addr_d = ADDR_W'(dst_d);
    end
    if (state_q == WAIT) begin
      wdata_d = ReadData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == READ) || (state_d == WAIT) || (state_d == WRITE);
      done_q  <= (state_d == DONE);
      rd_q    <= (state_d == READ);
      wr_q    <= (state_d == WRITE);
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ReadEn    = rd_q;
  assign WriteEn   = wr_q;
  assign ADDRESS   = addr_q;
  assign WriteData = wdata_q;

`ifdef SRAM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (load) begin
      csum_q <= '0;
    end else if (state_q == WAIT) begin
      csum_q <= csum_q ^ ReadData;
    end
  end

  assign checksum = csum_q;
`endif
endmodule

// File: doc/sram_copy_engine.md
Name: sram_copy_engine

Overview:
- Initiator for the team's 32x32 single-port synchronous SRAM: moves a block of words from a source region to a destination region inside that SRAM.
- Accepts a start pulse with src/dst/len, then sequences read, capture and write cycles on the SRAM port. Signals completion with a one-cycle done pulse.
- Sits beside the SRAM as its only master during a copy; the host configures it and polls busy/done.

Parameters:
- DATA_W, 32, data word width; must match the SRAM word.
- ADDR_W, 6, SRAM ADDRESS port width.
- DEPTH, 32, number of valid SRAM words; addresses wrap modulo DEPTH.

Ports:
- clk  in  1  rising-edge clock, shared with the SRAM.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  ADDR_W  first source word address.
- dst_addr  in  ADDR_W  first destination word address.
- len  in  ADDR_W  number of words to copy (0..DEPTH).
- busy  out  1  high from the cycle after accepted start until DONE.
- done  out  1  one-cycle pulse when the copy completes.
- ADDRESS  out  ADDR_W  SRAM address.
- WriteData  out  DATA_W  SRAM write data.
- WriteEn  out  1  SRAM write enable.
- ReadEn  out  1  SRAM read enable.
- ReadData  in  DATA_W  SRAM registered read data.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: busy=0, done=0, ADDRESS=0, WriteData=0, WriteEn=0, ReadEn=0. The FSM returns to IDLE and internal counters clear.
- Reset mid-copy: abort immediately. No further SRAM accesses occur; the partial copy is left in memory.
- Outputs are all registered.
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - start=1 latches src, dst and len into internal pointers and a counter.
  - len=0 goes directly to DONE.
  - Otherwise goes to READ.
  - start outside IDLE is ignored.
- READ (1 cycle): ReadEn=1, WriteEn=0, ADDRESS=src_ptr, WriteData=0. The SRAM registers the word at the end of this cycle.
- WAIT (1 cycle):
  - ReadEn=0, WriteEn=0.
  - ReadData is captured into a data register at the end of WAIT. The SRAM drives Z on ReadData after an idle cycle, so capture must happen exactly here.
- WRITE (1 cycle): WriteEn=1, ReadEn=0, ADDRESS=dst_ptr, WriteData=captured word.
  - Then src_ptr and dst_ptr each increment modulo DEPTH, and the counter decrements.
  - Counter reaches 0 -> DONE; else -> READ.
- DONE (1 cycle): done=1, busy=0, then -> IDLE. A start arriving in DONE is ignored.
- Bus rules:
  - WriteData is 0 whenever ReadEn=1; the memory qualifies reads on zero write data.
  - WriteEn and ReadEn are never high together.
  - ADDRESS bits above log2(DEPTH) are always 0.
- Latency: start edge to done pulse = 3*len + 1 cycles after the IDLE accept; len=0 gives 1 cycle.
- Wrap-around: src+len or dst+len beyond DEPTH-1 wraps to address 0.
- len > DEPTH is clamped to DEPTH.
- Overlap: the copy is strictly ascending, word by word. With dst in (src, src+len) the source is overwritten before it is read; this is defined behaviour and is not corrected.

Optional Feature:
- Macro: SRAM_COPY_CHECKSUM_EN.
- When defined:
  - Adds output checksum (DATA_W), an XOR of every captured word.
  - checksum clears on accepted start and updates at the WAIT capture.
  - It is valid and stable from the done pulse until the next accepted start; reset value is 0.
- When undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package sram_pkg holds DATA_W, ADDR_W and DEPTH constants plus the FSM state enum (IDLE, READ, WAIT, WRITE, DONE), so the SRAM and any future initiators agree.
- One natural sub-module, sram_copy_addr_gen: the src/dst pointers with modulo-DEPTH wrap and the remaining-word counter. The FSM stays in the top.

Test Plan:
- Preload mem[0..3] = 11,22,33,44; start src=0, dst=8, len=4 -> mem[8..11] = 11,22,33,44; done pulses 13 cycles after start; busy high for 12 of those cycles.
- start with len=0 -> no WriteEn or ReadEn ever asserted; done pulses the cycle after start.
- Wrap: src=30, dst=2, len=4, mem[30,31,0,1] = A,B,C,D -> mem[2..5] = A,B,C,D; ADDRESS never exceeds 31.
- start re-pulsed mid-copy, plus a new start in the DONE cycle -> both ignored; exactly one copy and one done pulse.
- rst_n low during the second WRITE of len=4 -> all outputs 0 asynchronously; only one destination word updated; FSM idle after release.
- With SRAM_COPY_CHECKSUM_EN: copy words 0xF0F0_0000 and 0x0F0F_FFFF -> checksum = 0xFFFF_FFFF at done.
